// File: rtl/qnigma_word_assembler_if.sv
// Stream bundle for qnigma_word_assembler.
//   in_*  : WIDTH-bit symbol stream into the assembler (valid/ready, in_lst marks packet end)
//   out_* : LENGTH*WIDTH-bit packed word out of the assembler (valid/ready, out_cnt symbols valid)
// slave  = assembler view, master = producer/consumer (bench) view.
interface qnigma_word_assembler_if #(
    parameter int WIDTH  = 8,
    parameter int LENGTH = 8
);
    logic [WIDTH-1:0]               in_dat;
    logic                           in_val;
    logic                           in_lst;
    logic                           in_rdy;
    logic [LENGTH*WIDTH-1:0]        out_dat;
    logic [$clog2(LENGTH+1)-1:0]    out_cnt;
    logic                           out_lst;
    logic                           out_val;
    logic                           out_rdy;

    modport slave (
        input  in_dat, in_val, in_lst,
        output in_rdy,
        output out_dat, out_cnt, out_lst, out_val,
        input  out_rdy
    );

    modport master (
        output in_dat, in_val, in_lst,
        input  in_rdy,
        input  out_dat, out_cnt, out_lst, out_val,
        output out_rdy
    );
endinterface

// File: rtl/qnigma_word_assembler.sv
// Stream-to-word gatherer. Shifts WIDTH-bit symbols into a LENGTH-slot
// accumulator and emits the packed word when full or on end of packet.
// Ports:
//   clk   : clock, rising edge
//   rst   : asynchronous active-low reset
//   clr   : synchronous abort, drops the partial word and the held word
//   bus   : slave side of qnigma_word_assembler_if (input stream + output word)
// Parameters:
//   WIDTH  : symbol width
//   LENGTH : symbols per word (>=2)
//   RIGHT  : 0 = newest symbol at index 0, 1 = newest symbol at index LENGTH-1
module qnigma_word_assembler #(
    parameter int WIDTH  = 8,
    parameter int LENGTH = 8,
    parameter bit RIGHT  = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    qnigma_word_assembler_if.slave bus
);
    localparam int CW = $clog2(LENGTH+1);

    logic [LENGTH-1:0][WIDTH-1:0] acc_q;
    logic [LENGTH-1:0][WIDTH-1:0] shifted;
    logic [LENGTH-1:0][WIDTH-1:0] dat_q;
    logic [CW-1:0]                sym_cnt;
    logic [CW-1:0]                cnt_q;
    logic                         lst_q;
    logic                         val_q;
    logic                         acc;
    logic                         take;
    logic                         done;

    // Ready depends only on the holding register, so a held word stalls input
    // and a word being taken frees the slot in the same cycle.
    assign bus.in_rdy = !val_q | bus.out_rdy;
    assign acc        = bus.in_val & bus.in_rdy;
    assign take       = val_q & bus.out_rdy;
    assign done       = (sym_cnt == CW'(LENGTH-1)) | bus.in_lst;

    if (RIGHT) begin : g_right
        assign shifted = {bus.in_dat, acc_q[LENGTH-1:1]};
    end else begin : g_left
        assign shifted = {acc_q[LENGTH-2:0], bus.in_dat};
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            acc_q   <= '0;
            sym_cnt <= '0;
            dat_q   <= '0;
            cnt_q   <= '0;
            lst_q   <= 1'b0;
            val_q   <= 1'b0;
        end else if (clr) begin
            acc_q   <= '0;
            sym_cnt <= '0;
            lst_q   <= 1'b0;
            val_q   <= 1'b0;
        end else begin
            // A completing symbol below overrides this, giving back-to-back words.
            if (take) val_q <= 1'b0;
            if (acc) begin
                if (done) begin
                    dat_q   <= shifted;
                    cnt_q   <= sym_cnt + 1'b1;
                    lst_q   <= bus.in_lst;
                    val_q   <= 1'b1;
                    // Next word starts from zero so unused slots read 0.
                    acc_q   <= '0;
                    sym_cnt <= '0;
                end else begin
                    acc_q   <= shifted;
                    sym_cnt <= sym_cnt + 1'b1;
                end
            end
        end
    end

    assign bus.out_dat = dat_q;
    assign bus.out_cnt = cnt_q;
    assign bus.out_lst = lst_q;
    assign bus.out_val = val_q;
endmodule

// File: tb/tb_qnigma_word_assembler.sv
// Bench for qnigma_word_assembler: one left-shift and one right-shift
// instance fed the same stream, checked against a symbol-queue model.
module tb_qnigma_word_assembler;
    localparam int W = 8;
    localparam int L = 4;

    typedef struct packed {
        logic [L*W-1:0] dat;
        logic [2:0]     cnt;
        logic           lst;
    } word_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       clr = 1'b0;
    logic [W-1:0] in_dat = '0;
    logic       in_val = 1'b0;
    logic       in_lst = 1'b0;
    logic       out_rdy = 1'b0;

    int n_chk = 0;
    int n_bad = 0;
    int nw0 = 0;
    int nw1 = 0;

    always #5 clk = ~clk;

    qnigma_word_assembler_if #(.WIDTH(W), .LENGTH(L)) b0 ();
    qnigma_word_assembler_if #(.WIDTH(W), .LENGTH(L)) b1 ();

    assign b0.in_dat  = in_dat;
    assign b0.in_val  = in_val;
    assign b0.in_lst  = in_lst;
    assign b0.out_rdy = out_rdy;
    assign b1.in_dat  = in_dat;
    assign b1.in_val  = in_val;
    assign b1.in_lst  = in_lst;
    assign b1.out_rdy = out_rdy;

    qnigma_word_assembler #(.WIDTH(W), .LENGTH(L), .RIGHT(1'b0)) u0 (
        .clk(clk), .rst(rst_n), .clr(clr), .bus(b0));
    qnigma_word_assembler #(.WIDTH(W), .LENGTH(L), .RIGHT(1'b1)) u1 (
        .clk(clk), .rst(rst_n), .clr(clr), .bus(b1));

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Reference model: symbols of the current packet fragment, and the words
    // each instance is expected to deliver, in order.
    logic [W-1:0] cur[$];
    word_t        q0[$];
    word_t        q1[$];
    logic         pend = 1'b0;
    logic         hold = 1'b0;
    logic [L*W-1:0] hd0, hd1;
    logic [2:0]   hc0;
    logic         hl0;

    always @(negedge clk) begin
        word_t w0, w1, e;
        int n;
        if (rst_n && pend) begin
            chk("lat0", b0.out_val, 1);
            chk("lat1", b1.out_val, 1);
        end
        pend = 1'b0;
        if (rst_n && hold) begin
            chk("hold_dat0", b0.out_dat, hd0);
            chk("hold_cnt0", b0.out_cnt, hc0);
            chk("hold_lst0", b0.out_lst, hl0);
            chk("hold_dat1", b1.out_dat, hd1);
        end
        hold = 1'b0;
        if (!rst_n || clr) begin
            cur.delete();
            q0.delete();
            q1.delete();
        end else begin
            if (b0.out_val && !out_rdy) begin
                chk("hold_rdy", b0.in_rdy, 0);
                hold = 1'b1;
                hd0 = b0.out_dat; hc0 = b0.out_cnt; hl0 = b0.out_lst; hd1 = b1.out_dat;
            end
            if (b0.out_val && out_rdy) begin
                nw0++;
                if (q0.size() == 0) chk("spurious0", 1, 0);
                else begin
                    e = q0.pop_front();
                    chk("dat0", b0.out_dat, e.dat);
                    chk("cnt0", b0.out_cnt, e.cnt);
                    chk("lst0", b0.out_lst, e.lst);
                end
            end
            if (b1.out_val && out_rdy) begin
                nw1++;
                if (q1.size() == 0) chk("spurious1", 1, 0);
                else begin
                    e = q1.pop_front();
                    chk("dat1", b1.out_dat, e.dat);
                    chk("cnt1", b1.out_cnt, e.cnt);
                    chk("lst1", b1.out_lst, e.lst);
                end
            end
            if (in_val && b0.in_rdy) begin
                cur.push_back(in_dat);
                if (cur.size() == L || in_lst) begin
                    n = cur.size();
                    w0 = '0; w1 = '0;
                    // oldest symbol k=0: left mode at n-1 downwards, right mode at L-n upwards
                    for (int k = 0; k < n; k++) begin
                        w0.dat[(n-1-k)*W +: W] = cur[k];
                        w1.dat[(L-n+k)*W +: W] = cur[k];
                    end
                    w0.cnt = 3'(n); w1.cnt = 3'(n);
                    w0.lst = in_lst; w1.lst = in_lst;
                    q0.push_back(w0);
                    q1.push_back(w1);
                    cur.delete();
                    pend = 1'b1;
                end
            end
        end
    end

    // Entered and left at posedge+1; holds the symbol until accepted.
    task automatic send(input logic [W-1:0] d, input logic l);
        int n;
        n = 0;
        in_val = 1'b1; in_dat = d; in_lst = l;
        @(negedge clk);
        while (!b0.in_rdy && n < 200) begin
            n++;
            @(negedge clk);
        end
        if (!b0.in_rdy) chk("send_timeout", 0, 1);
        @(posedge clk); #1;
    endtask

    task automatic idle(input int c);
        in_val = 1'b0; in_lst = 1'b0;
        repeat (c) begin @(posedge clk); #1; end
    endtask

    logic rnd_on = 1'b0;
    int   base;
    time  t0;

    initial begin
        out_rdy = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_val", b0.out_val, 0);
        chk("rst_dat", b0.out_dat, 0);
        chk("rst_cnt", b0.out_cnt, 0);
        chk("rst_lst", b0.out_lst, 0);
        chk("rst_rdy", b0.in_rdy, 1);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // full word
        send(8'h11, 0); send(8'h22, 0); send(8'h33, 0); send(8'h44, 0);
        in_val = 1'b0;
        chk("full_val", b0.out_val, 1);
        chk("full_dat0", b0.out_dat, 32'h11223344);
        chk("full_cnt", b0.out_cnt, 4);
        chk("full_lst", b0.out_lst, 0);
        chk("full_dat1", b1.out_dat, 32'h44332211);
        idle(1);

        // short packet
        send(8'hAA, 0); send(8'hBB, 1);
        in_val = 1'b0;
        chk("part_dat0", b0.out_dat, 32'h0000AABB);
        chk("part_dat1", b1.out_dat, 32'hBBAA0000);
        chk("part_cnt", b0.out_cnt, 2);
        chk("part_lst", b0.out_lst, 1);
        idle(1);

        // last on the LENGTH-th symbol, then single-symbol packet
        send(8'h11, 0); send(8'h22, 0); send(8'h33, 0); send(8'h44, 1);
        in_val = 1'b0;
        chk("lastfull_dat1", b1.out_dat, 32'h44332211);
        chk("lastfull_cnt", b1.out_cnt, 4);
        chk("lastfull_lst", b1.out_lst, 1);
        send(8'h55, 1);
        in_val = 1'b0;
        chk("one_dat1", b1.out_dat, 32'h55000000);
        chk("one_dat0", b0.out_dat, 32'h00000055);
        chk("one_cnt", b1.out_cnt, 1);
        idle(2);
        chk("no_empty_word", b0.out_val, 0);

        // backpressure
        out_rdy = 1'b0;
        send(8'h01, 0); send(8'h02, 0); send(8'h03, 0); send(8'h04, 0);
        in_val = 1'b1; in_dat = 8'h05; in_lst = 1'b0;
        repeat (5) begin
            @(negedge clk);
            chk("bp_rdy", b0.in_rdy, 0);
            chk("bp_dat", b0.out_dat, 32'h01020304);
            chk("bp_cnt", b0.out_cnt, 4);
        end
        @(posedge clk); #1;
        out_rdy = 1'b1;
        t0 = $time;
        for (int i = 5; i <= 12; i++) send(8'(i), 0);
        chk("thruput", ($time - t0) / 10, 8);
        idle(2);

        // clr mid-word, with a symbol presented during clr
        send(8'hA1, 0); send(8'hA2, 0); send(8'hA3, 0);
        in_val = 1'b1; in_dat = 8'hEE; clr = 1'b1;
        @(posedge clk); #1;
        clr = 1'b0; in_val = 1'b0;
        chk("clr_val", b0.out_val, 0);
        base = nw0;
        send(8'hB1, 0); send(8'hB2, 0); send(8'hB3, 0); send(8'hB4, 0);
        in_val = 1'b0;
        chk("clr_dat0", b0.out_dat, 32'hB1B2B3B4);
        chk("clr_cnt", b0.out_cnt, 4);
        idle(3);
        chk("clr_words", nw0 - base, 1);

        // reset mid-word
        send(8'hC1, 0); send(8'hC2, 0); send(8'hC3, 0);
        in_val = 1'b0;
        rst_n = 1'b0;
        #1;
        chk("arst_val", b0.out_val, 0);
        chk("arst_dat", b0.out_dat, 0);
        chk("arst_cnt", b0.out_cnt, 0);
        chk("arst_lst", b0.out_lst, 0);
        chk("arst_dat1", b1.out_dat, 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        base = nw0;
        send(8'hD1, 0); send(8'hD2, 0); send(8'hD3, 0); send(8'hD4, 0);
        in_val = 1'b0;
        chk("arst_rec_dat0", b0.out_dat, 32'hD1D2D3D4);
        chk("arst_rec_cnt", b0.out_cnt, 4);
        idle(3);
        chk("arst_words", nw0 - base, 1);

        // random stream with random stalls
        rnd_on = 1'b1;
        fork
            begin
                for (int i = 0; i < 1000; i++) begin
                    if ($urandom_range(0, 3) == 0) idle(1);
                    send(8'($urandom), $urandom_range(0, 5) == 0);
                end
                in_val = 1'b0;
                rnd_on = 1'b0;
            end
            begin
                while (rnd_on) begin
                    out_rdy = $urandom_range(0, 3) != 0;
                    @(posedge clk); #1;
                end
            end
        join
        out_rdy = 1'b1;
        idle(10);
        chk("drain0", q0.size(), 0);
        chk("drain1", q1.size(), 0);
        chk("words_match", nw0, nw1);

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end
endmodule
